// File: rtl/dac_spi_multi_if.sv
// Bus bundle for the N-channel serial DAC write engine: request side from the
// CNN edge datapath and the shared/per-channel pins toward the DAC array.
interface dac_spi_multi_if #(
  parameter int N_CH = 4,
  parameter int DW   = 16
);
  logic                 start;
  logic [N_CH*DW-1:0]   data;
  logic [N_CH-1:0]      ch_en;
  logic                 auto_ldac;
  logic                 ldac_req;
  logic                 busy;
  logic                 done;
  logic                 sck;
  logic                 dac_cs;
  logic [N_CH-1:0]      sdi;
  logic [N_CH-1:0]      ldac;

  modport master (
    output start, data, ch_en, auto_ldac, ldac_req,
    input  busy, done, sck, dac_cs, sdi, ldac
  );

  modport slave (
    input  start, data, ch_en, auto_ldac, ldac_req,
    output busy, done, sck, dac_cs, sdi, ldac
  );
endinterface

// File: rtl/dac_spi_multi.sv
// N-channel parallel serial DAC writer: one DW-bit word per channel shifted
// MSB first on its own sdi line, shared sck/dac_cs, per-channel ldac strobes
// with optional deferred (broadcast) load of the last written channel set.
module dac_spi_multi #(
  parameter int N_CH    = 4,
  parameter int DW      = 16,
  parameter int CLK_DIV = 4,
  parameter int LDAC_W  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  dac_spi_multi_if.slave  bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_CS_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT    = 3'd2;
  localparam logic [2:0] S_CS_HOLD  = 3'd3;
  localparam logic [2:0] S_LDAC     = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  // One counter serves every timed phase; the longest is a full bit period.
  localparam int CNT_MAX = (2 * CLK_DIV > LDAC_W) ? 2 * CLK_DIV : LDAC_W;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = (DW > 1) ? $clog2(DW) : 1;

  localparam logic [CNT_W-1:0] CNT_EDGE = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LDAC = CNT_W'(LDAC_W - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DW - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [BIT_W-1:0] bit_cnt;
  logic [N_CH-1:0]  mask;
  logic             auto_lat;
  logic [DW-1:0]    word [N_CH];

  logic             accept_write;
  logic             frame;
  logic             bit_end;
  logic [N_CH-1:0]  sdi_c;
  logic [N_CH-1:0]  ldac_c;

  assign accept_write = bus.start && (bus.ch_en != '0);
  assign frame        = (state == S_CS_SETUP) || (state == S_SHIFT) || (state == S_CS_HOLD);
  assign bit_end      = (state == S_SHIFT) && (cnt == CNT_BIT);

  // Control FSM: phase sequencing, bit counting and latching of the load mask.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      mask     <= '0;
      auto_lat <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          if (bus.start) begin
            // An empty channel set completes without touching the bus or mask.
            if (accept_write) begin
              mask     <= bus.ch_en;
              auto_lat <= bus.auto_ldac;
              state    <= S_CS_SETUP;
            end else begin
              state <= S_DONE;
            end
          end else if (bus.ldac_req) begin
            state <= S_LDAC;
          end
        end
        S_CS_SETUP: begin
          if (cnt == CNT_EDGE) begin
            cnt   <= '0;
            state <= S_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (cnt == CNT_BIT) begin
            cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= S_CS_HOLD;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_CS_HOLD: begin
          if (cnt == CNT_EDGE) begin
            cnt   <= '0;
            state <= auto_lat ? S_LDAC : S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_LDAC: begin
          if (cnt == CNT_LDAC) begin
            cnt   <= '0;
            state <= S_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: begin
          cnt     <= '0;
          bit_cnt <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // Word shift registers: load on accept, advance as sck falls (last bit held).
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if ((state == S_IDLE) && accept_write)
        word[i] <= bus.data[i*DW +: DW];
      else if (bit_end && (bit_cnt != BIT_LAST))
        word[i] <= word[i] << 1;
    end
  end

  // Pin decode: sdi gated by frame and mask so reset or idle forces it low.
  always_comb begin
    sdi_c  = '0;
    ldac_c = '1;
    for (int i = 0; i < N_CH; i++) begin
      sdi_c[i]  = frame && mask[i] && word[i][DW-1];
      ldac_c[i] = !((state == S_LDAC) && mask[i]);
    end
  end

  assign bus.sdi    = sdi_c;
  assign bus.ldac   = ldac_c;
  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = (state == S_DONE);
  assign bus.sck    = (state == S_SHIFT) && (cnt >= CNT_HALF);
  assign bus.dac_cs = !frame;

endmodule

// File: tb/tb_dac_spi_multi.sv
// Directed bench for dac_spi_multi: default 4-channel instance plus an
// 8-channel, DW=12, CLK_DIV=1, LDAC_W=1 instance.
module tb_dac_spi_multi;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dac_spi_multi_if #(.N_CH(4), .DW(16)) bif ();
  dac_spi_multi #(.N_CH(4), .DW(16), .CLK_DIV(4), .LDAC_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif)
  );

  dac_spi_multi_if #(.N_CH(8), .DW(12)) bif8 ();
  dac_spi_multi #(.N_CH(8), .DW(12), .CLK_DIV(1), .LDAC_W(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(bif8)
  );

  int checks = 0;
  int failures = 0;

  // Statistics of the 4-channel instance, restarted when tok changes.
  int tok = 0, seen = 0;
  int cyc, rises, cs_low, ldac_low, busy_cyc, done_cnt, done_at;
  logic [3:0]  ldac_seen, sdi_or;
  logic [15:0] rx [4];
  logic        prev_sck = 1'b0;

  always @(negedge clk) begin
    if (tok != seen) begin
      seen = tok; cyc = 0; rises = 0; cs_low = 0; ldac_low = 0;
      busy_cyc = 0; done_cnt = 0; done_at = -1;
      ldac_seen = 4'hF; sdi_or = 4'h0;
      for (int i = 0; i < 4; i++) rx[i] = 16'h0;
    end else begin
      cyc++;
    end
    if (bif.sck && !prev_sck) begin
      rises++;
      for (int i = 0; i < 4; i++) rx[i] = {rx[i][14:0], bif.sdi[i]};
    end
    prev_sck = bif.sck;
    if (!bif.dac_cs) cs_low++;
    if (bif.ldac != 4'hF) begin ldac_low++; ldac_seen = bif.ldac; end
    if (bif.busy) busy_cyc++;
    sdi_or = sdi_or | bif.sdi;
    if (bif.done) begin done_cnt++; if (done_at < 0) done_at = cyc; end
  end

  // Statistics of the 8-channel instance.
  int tok8 = 0, seen8 = 0;
  int cyc8, rises8, ldac_low8, busy_cyc8, done_cnt8, done_at8;
  logic [11:0] rx8 [8];
  logic        prev_sck8 = 1'b0;

  always @(negedge clk) begin
    if (tok8 != seen8) begin
      seen8 = tok8; cyc8 = 0; rises8 = 0; ldac_low8 = 0;
      busy_cyc8 = 0; done_cnt8 = 0; done_at8 = -1;
      for (int i = 0; i < 8; i++) rx8[i] = 12'h0;
    end else begin
      cyc8++;
    end
    if (bif8.sck && !prev_sck8) begin
      rises8++;
      for (int i = 0; i < 8; i++) rx8[i] = {rx8[i][10:0], bif8.sdi[i]};
    end
    prev_sck8 = bif8.sck;
    if (bif8.ldac != 8'hFF) ldac_low8++;
    if (bif8.busy) busy_cyc8++;
    if (bif8.done) begin done_cnt8++; if (done_at8 < 0) done_at8 = cyc8; end
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed='h%0h expected='h%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic l, input logic clr);
    @(posedge clk); #1;
    if (clr) tok++;
    bif.start = s; bif.ldac_req = l;
    @(posedge clk); #1;
    bif.start = 1'b0; bif.ldac_req = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 400) begin @(posedge clk); n++; end
    chk(tag, longint'(done_cnt != 0), 1);
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic drive8();
    @(posedge clk); #1;
    tok8++;
    bif8.start = 1'b1;
    @(posedge clk); #1;
    bif8.start = 1'b0;
  endtask

  task automatic wait_done8(input string tag);
    int n = 0;
    while (done_cnt8 == 0 && n < 200) begin @(posedge clk); n++; end
    chk(tag, longint'(done_cnt8 != 0), 1);
    @(posedge clk); @(posedge clk); #1;
  endtask

  logic [11:0] exp8 [8] = '{12'hABC, 12'h123, 12'hFFF, 12'h000,
                            12'h800, 12'h001, 12'h5A5, 12'hA5A};

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.start = 0; bif.ldac_req = 0; bif.auto_ldac = 0; bif.ch_en = '0; bif.data = '0;
    bif8.start = 0; bif8.ldac_req = 0; bif8.auto_ldac = 0; bif8.ch_en = '0; bif8.data = '0;

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst_busy", bif.busy, 0);
    chk("rst_done", bif.done, 0);
    chk("rst_sck", bif.sck, 0);
    chk("rst_cs", bif.dac_cs, 1);
    chk("rst_sdi", bif.sdi, 0);
    chk("rst_ldac", bif.ldac, 4'hF);
    chk("rst8_cs", bif8.dac_cs, 1);
    chk("rst8_ldac", bif8.ldac, 8'hFF);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full write, all channels, automatic load
    bif.data = {16'hFFFF, 16'h8000, 16'h0001, 16'hA5C3};
    bif.ch_en = 4'hF; bif.auto_ldac = 1'b1;
    drive(1, 0, 1);
    wait_done("t1_timeout");
    chk("t1_rx0", rx[0], 16'hA5C3);
    chk("t1_rx1", rx[1], 16'h0001);
    chk("t1_rx2", rx[2], 16'h8000);
    chk("t1_rx3", rx[3], 16'hFFFF);
    chk("t1_rises", rises, 16);
    chk("t1_cs_low", cs_low, 136);
    chk("t1_ldac_low", ldac_low, 2);
    chk("t1_ldac_val", ldac_seen, 4'h0);
    chk("t1_done_at", done_at, 139);
    chk("t1_busy_cyc", busy_cyc, 139);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_busy_after", bif.busy, 0);

    // Partial write with deferred load
    bif.data = {16'h1234, 16'hBEEF, 16'h0F0F, 16'h5555};
    bif.ch_en = 4'b0101; bif.auto_ldac = 1'b0;
    drive(1, 0, 1);
    wait_done("t2_timeout");
    chk("t2_rx0", rx[0], 16'h5555);
    chk("t2_rx2", rx[2], 16'hBEEF);
    chk("t2_rx1", rx[1], 16'h0);
    chk("t2_sdi_off", sdi_or & 4'b1010, 0);
    chk("t2_ldac_low", ldac_low, 0);
    chk("t2_busy_cyc", busy_cyc, 137);
    chk("t2_done_at", done_at, 137);
    drive(0, 1, 1);
    wait_done("t2l_timeout");
    chk("t2l_ldac_val", ldac_seen, 4'b1010);
    chk("t2l_ldac_low", ldac_low, 2);
    chk("t2l_done_at", done_at, 3);
    chk("t2l_busy_cyc", busy_cyc, 3);
    chk("t2l_rises", rises, 0);

    // Empty channel set
    bif.ch_en = 4'b0000; bif.auto_ldac = 1'b1;
    drive(1, 0, 1);
    wait_done("t3_timeout");
    chk("t3_done_at", done_at, 1);
    chk("t3_busy_cyc", busy_cyc, 1);
    chk("t3_rises", rises, 0);
    chk("t3_cs_low", cs_low, 0);
    chk("t3_ldac_low", ldac_low, 0);
    drive(0, 1, 1);
    wait_done("t3l_timeout");
    chk("t3l_mask_kept", ldac_seen, 4'b1010);
    chk("t3l_ldac_low", ldac_low, 2);

    // Requests during a transfer are ignored
    bif.data = {16'h0F0F, 16'hF0F0, 16'h3C3C, 16'hC3C3};
    bif.ch_en = 4'hF; bif.auto_ldac = 1'b1;
    drive(1, 0, 1);
    repeat (30) @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      #1;
      bif.start = 1'b1; bif.ldac_req = 1'b1; bif.ch_en = 4'b0010;
      bif.data = '0; bif.auto_ldac = 1'b0;
      @(posedge clk); #1;
      bif.start = 1'b0; bif.ldac_req = 1'b0;
      repeat (7) @(posedge clk);
    end
    wait_done("t4_timeout");
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_busy_cyc", busy_cyc, 139);
    chk("t4_rx0", rx[0], 16'hC3C3);
    chk("t4_rx1", rx[1], 16'h3C3C);
    chk("t4_rx2", rx[2], 16'hF0F0);
    chk("t4_rx3", rx[3], 16'h0F0F);
    chk("t4_ldac_val", ldac_seen, 4'h0);
    chk("t4_busy_after", bif.busy, 0);

    // start and ldac_req together in IDLE: write wins, no load
    bif.data = {16'h0, 16'h0, 16'h00FF, 16'hFF00};
    bif.ch_en = 4'b0011; bif.auto_ldac = 1'b0;
    drive(1, 1, 1);
    wait_done("t4s_timeout");
    chk("t4s_busy_cyc", busy_cyc, 137);
    chk("t4s_cs_low", cs_low, 136);
    chk("t4s_ldac_low", ldac_low, 0);
    chk("t4s_done_cnt", done_cnt, 1);
    chk("t4s_rx0", rx[0], 16'hFF00);
    chk("t4s_rx1", rx[1], 16'h00FF);

    // Asynchronous reset during bit 7, sck high
    bif.data = {16'hFFFF, 16'h8000, 16'h0001, 16'hA5C3};
    bif.ch_en = 4'hF; bif.auto_ldac = 1'b1;
    drive(1, 0, 1);
    repeat (65) @(posedge clk);
    #2;
    chk("t5_pre_cs", bif.dac_cs, 0);
    chk("t5_pre_sck", bif.sck, 1);
    chk("t5_pre_busy", bif.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_cs", bif.dac_cs, 1);
    chk("t5_sck", bif.sck, 0);
    chk("t5_sdi", bif.sdi, 0);
    chk("t5_busy", bif.busy, 0);
    chk("t5_done", bif.done, 0);
    chk("t5_ldac", bif.ldac, 4'hF);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    drive(0, 1, 1);
    wait_done("t5l_timeout");
    chk("t5l_mask_cleared", ldac_low, 0);
    chk("t5l_done_at", done_at, 3);
    drive(1, 0, 1);
    wait_done("t5w_timeout");
    chk("t5w_busy_cyc", busy_cyc, 139);
    chk("t5w_done_at", done_at, 139);
    chk("t5w_rises", rises, 16);
    chk("t5w_rx0", rx[0], 16'hA5C3);
    chk("t5w_rx3", rx[3], 16'hFFFF);

    // 8-channel, 12-bit, fastest timing
    for (int i = 0; i < 8; i++) bif8.data[i*12 +: 12] = exp8[i];
    bif8.ch_en = 8'hFF; bif8.auto_ldac = 1'b1;
    drive8();
    wait_done8("t6_timeout");
    chk("t6_rises", rises8, 12);
    chk("t6_busy_cyc", busy_cyc8, 28);
    chk("t6_done_at", done_at8, 28);
    chk("t6_ldac_low", ldac_low8, 1);
    for (int i = 0; i < 8; i++) chk($sformatf("t6_rx%0d", i), rx8[i], exp8[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
